// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with valid/ready handshakes.
// Shift-add multiplier and restoring divider share one {hi, lo} register pair.
// Optional macro MULDIV_FAST_MUL_EN: multiplies use a single 33x33 signed
// multiplier at accept and skip the iterative path.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            Flush,
  input  logic            InValid,
  output logic            InReady,
  input  logic [2:0]      MulDivOp,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] Result
);

  localparam int unsigned CNT_W = 5;
  localparam int unsigned DW    = 2 * XLEN;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q, state_nxt;
  logic [2:0]        op_q, op_nxt;
  logic              neg_res_q, neg_res_nxt;
  logic              neg_rem_q, neg_rem_nxt;
  logic [XLEN-1:0]   hi_q, hi_nxt;
  logic [XLEN-1:0]   lo_q, lo_nxt;
  logic [XLEN-1:0]   m_q, m_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              out_valid_q, out_valid_nxt;
  logic [XLEN-1:0]   result_q, result_nxt;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              is_div, div_zero, div_ovf;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_trial;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [DW-1:0]     prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;

  // Request decode: operand signedness, magnitudes and special cases
  assign a_signed = (MulDivOp == OP_MULH) || (MulDivOp == OP_MULHSU) ||
                    (MulDivOp == OP_DIV)  || (MulDivOp == OP_REM);
  assign b_signed = (MulDivOp == OP_MULH) || (MulDivOp == OP_DIV) || (MulDivOp == OP_REM);
  assign a_neg    = a_signed & SrcA[XLEN-1];
  assign b_neg    = b_signed & SrcB[XLEN-1];
  assign mag_a    = a_neg ? -SrcA : SrcA;
  assign mag_b    = b_neg ? -SrcB : SrcB;
  assign is_div   = MulDivOp[2];
  assign div_zero = is_div && (SrcB == '0);
  assign div_ovf  = ((MulDivOp == OP_DIV) || (MulDivOp == OP_REM)) &&
                    (SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (SrcB == '1);

  // One shift-add step: lo holds the multiplier bits, m the multiplicand
  assign mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? m_q : '0)};

  // One restoring-divide step: hi is the partial remainder, lo shifts dividend out / quotient in
  assign div_trial = {hi_q, lo_q[XLEN-1]};
  assign div_ge    = div_trial >= {1'b0, m_q};
  assign div_diff  = XLEN'(div_trial - {1'b0, m_q});

  // Sign correction applied in FIX
  assign prod_fix  = neg_res_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quot_fix  = neg_res_q ? -lo_q : lo_q;
  assign rem_fix   = neg_rem_q ? -hi_q : hi_q;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0] fast_a, fast_b;
  logic [DW-1:0]        fast_prod;

  // Single-cycle signed 33x33 product of sign/zero-extended operands
  assign fast_a    = {a_signed & SrcA[XLEN-1], SrcA};
  assign fast_b    = {b_signed & SrcB[XLEN-1], SrcB};
  assign fast_prod = DW'(fast_a * fast_b);
`endif

  // Next-state and datapath update
  always_comb begin
    state_nxt     = state_q;
    op_nxt        = op_q;
    neg_res_nxt   = neg_res_q;
    neg_rem_nxt   = neg_rem_q;
    hi_nxt        = hi_q;
    lo_nxt        = lo_q;
    m_nxt         = m_q;
    cnt_nxt       = cnt_q;
    out_valid_nxt = out_valid_q;
    result_nxt    = result_q;

    case (state_q)
      IDLE: begin
        if (InValid && !Flush) begin
          op_nxt      = MulDivOp;
          neg_res_nxt = a_neg ^ b_neg;
          neg_rem_nxt = a_neg;
          cnt_nxt     = '0;
          hi_nxt      = '0;
          lo_nxt      = is_div ? mag_a : mag_b;
          m_nxt       = is_div ? mag_b : mag_a;
          if (div_zero) begin
            result_nxt    = MulDivOp[1] ? SrcA : '1;
            out_valid_nxt = 1'b1;
            state_nxt     = DONE;
          end else if (div_ovf) begin
            result_nxt    = MulDivOp[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            out_valid_nxt = 1'b1;
            state_nxt     = DONE;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!is_div) begin
            result_nxt    = (MulDivOp == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[DW-1:XLEN];
            out_valid_nxt = 1'b1;
            state_nxt     = DONE;
`endif
          end else begin
            state_nxt = CALC;
          end
        end
      end
      CALC: begin
        if (op_q[2]) begin
          hi_nxt = div_ge ? div_diff : div_trial[XLEN-1:0];
          lo_nxt = {lo_q[XLEN-2:0], div_ge};
        end else begin
          hi_nxt = mul_sum[XLEN:1];
          lo_nxt = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        cnt_nxt = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) state_nxt = FIX;
      end
      FIX: begin
        case (op_q)
          OP_MUL:                       result_nxt = prod_fix[XLEN-1:0];
          OP_MULH, OP_MULHSU, OP_MULHU: result_nxt = prod_fix[DW-1:XLEN];
          OP_DIV, OP_DIVU:              result_nxt = quot_fix;
          OP_REM, OP_REMU:              result_nxt = rem_fix;
          default:                      result_nxt = '0;
        endcase
        out_valid_nxt = 1'b1;
        state_nxt     = DONE;
      end
      DONE: begin
        if (OutReady) begin
          out_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (Flush) begin
      state_nxt     = IDLE;
      out_valid_nxt = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_nxt;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_q        <= '0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      m_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      op_q        <= op_nxt;
      neg_res_q   <= neg_res_nxt;
      neg_rem_q   <= neg_rem_nxt;
      hi_q        <= hi_nxt;
      lo_q        <= lo_nxt;
      m_q         <= m_nxt;
      cnt_q       <= cnt_nxt;
      out_valid_q <= out_valid_nxt;
      result_q    <= result_nxt;
    end
  end

  assign InReady  = (state_q == IDLE) && reset_n;
  assign OutValid = out_valid_q;
  assign Result   = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against an
// arithmetic reference model, including latency, hold, flush and reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        Flush = 1'b0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [2:0]  MulDivOp = 3'b000;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic [31:0] Result;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .Flush    (Flush),
    .InValid  (InValid),
    .InReady  (InReady),
    .MulDivOp (MulDivOp),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Result   (Result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RV32M semantics from plain arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub, p;
    logic [63:0] up;
    int          ia, ib;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'b0, b});
    ia  = $signed(a);
    ib  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return 34;
  endfunction

  // Wait for OutValid after an accept; returns the cycle number it appeared in
  task automatic wait_out(output int cyc);
    cyc = 1;
    while (!OutValid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // One full transaction with latency, result and handshake checks
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    int cyc;
    cyc = 0;
    while (!InReady && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ".in_ready"}, 32'(InReady), 32'd1);
    MulDivOp = op; SrcA = a; SrcB = b; InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
    wait_out(cyc);
    check({tag, ".latency"}, 32'(cyc), 32'(exp_latency(op, a, b)));
    check({tag, ".result"}, Result, model(op, a, b));
    OutReady = 1'b1;
    @(posedge clk); #1;
    OutReady = 1'b0;
    check({tag, ".valid_clr"}, 32'(OutValid), 32'd0);
    check({tag, ".ready_back"}, 32'(InReady), 32'd1);
  endtask

  initial begin
    int cyc;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic [31:0] held;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", 32'(InReady), 32'd0);
    check("rst.out_valid", 32'(OutValid), 32'd0);
    check("rst.result", Result, 32'd0);
    reset_n = 1'b1;
    #1;
    check("rst.in_ready_rel", 32'(InReady), 32'd1);

    // Directed cases
    do_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, "mul_7x-3");
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh_min");
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
    do_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, "div_-7_2");
    do_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, "rem_-7_2");
    do_op(3'd5, 32'd100, 32'd7, "divu_100_7");
    do_op(3'd7, 32'd100, 32'd7, "remu_100_7");
    do_op(3'd5, 32'd5, 32'd0, "divu_by0");
    do_op(3'd6, 32'd5, 32'd0, "rem_by0");
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");

    // Randomized operations with forced corner cases
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 15));
        default: ;
      endcase
      do_op(rop, ra, rb, "rand");
    end

    // Hold DONE with OutReady low while a second request waits
    MulDivOp = 3'd0; SrcA = 32'd7; SrcB = 32'hFFFF_FFFD; InValid = 1'b1;
    @(posedge clk); #1;
    MulDivOp = 3'd5; SrcA = 32'd100; SrcB = 32'd7;
    wait_out(cyc);
    check("hold.latency", 32'(cyc), 32'(exp_latency(3'd0, 32'd7, 32'hFFFF_FFFD)));
    held = model(3'd0, 32'd7, 32'hFFFF_FFFD);
    for (int i = 0; i < 10; i++) begin
      check("hold.result", Result, held);
      check("hold.in_ready", 32'(InReady), 32'd0);
      check("hold.out_valid", 32'(OutValid), 32'd1);
      @(posedge clk); #1;
    end
    OutReady = 1'b1;
    @(posedge clk); #1;
    OutReady = 1'b0;
    check("hold.ready_after", 32'(InReady), 32'd1);
    check("hold.valid_after", 32'(OutValid), 32'd0);
    @(posedge clk); #1;
    InValid = 1'b0;
    check("hold.second_accepted", 32'(InReady), 32'd0);
    wait_out(cyc);
    check("hold.second_latency", 32'(cyc), 32'd34);
    check("hold.second_result", Result, 32'd14);
    OutReady = 1'b1;
    @(posedge clk); #1;
    OutReady = 1'b0;

    // Flush at cycle 10 of a DIVU, with a request presented alongside
    MulDivOp = 3'd5; SrcA = 32'd1000; SrcB = 32'd7; InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
    end
    check("flush.busy", 32'(InReady), 32'd0);
    Flush = 1'b1; InValid = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0; InValid = 1'b0;
    check("flush.out_valid", 32'(OutValid), 32'd0);
    check("flush.idle", 32'(InReady), 32'd1);
    do_op(3'd5, 32'd9, 32'd3, "flush.divu_9_3");

    // Reset asserted mid-CALC
    MulDivOp = 3'd4; SrcA = 32'hFFFF_FFF9; SrcB = 32'd2; InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("mrst.out_valid", 32'(OutValid), 32'd0);
    check("mrst.result", Result, 32'd0);
    check("mrst.in_ready", 32'(InReady), 32'd0);
    reset_n = 1'b1;
    #1;
    do_op(3'd5, 32'd9, 32'd3, "mrst.divu_9_3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
